enc1s_unit: RTL and testbench

ENC1S_UNIT -- requirements
Module: enc1s

---
 rtl/enc1s_unit.sv | 181 ++++++++++++++++++
 tb/tb_enc1s_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/enc1s_unit.sv
// enc1s_unit -- single-cycle AES / SM4 byte-wise round helper.
//
// Picks one byte of rs2, runs it through an S-box (AES forward/inverse, or
// SM4), applies the matching linear layer, rotates the word back into the
// byte lane it came from and XORs it into rs1. Registered result, one
// operation per cycle, no backpressure.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset (clears rd and valid_o)
//   valid_i  operands valid this cycle
//   rs1      32-bit XOR accumulator operand
//   rs2      32-bit source word, one byte selected by fn[1:0]
//   fn       fn[1:0] byte select, fn[4:2] operation
//   valid_o  rd holds a new result this cycle
//   rd       registered result
//
// Build option: define ENC1S_SM4_EN to include the SM4 S-box and linear
// layers (ops 4/5). Without it, ops 4/5 return rs1 unchanged.

module enc1s_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_i,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic [4:0]  fn,
   output logic        valid_o,
   output logic [31:0] rd
);

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   // a^254 == a^-1 (and 0 maps to 0): product of a^2, a^4 ... a^128
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = gf_mul(a, a);
      acc = sq;
      for (int i = 0; i < 6; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   logic [1:0]  sel;
   logic [2:0]  op;
   logic [7:0]  b;
   logic        aes_dec;
   logic [7:0]  inv_in;
   logic [7:0]  inv_out;
   logic [7:0]  aes_x;
   logic [31:0] mc_enc;
   logic [31:0] mc_dec;
   logic [31:0] w;
   logic [31:0] w_rot;
   logic [31:0] result_next;
   logic [31:0] rd_reg;
   logic        valid_reg;

   assign sel = fn[1:0];
   assign op  = fn[4:2];

   always_comb begin
      b = rs2[7:0];
      case (sel)
         2'd0: b = rs2[7:0];
         2'd1: b = rs2[15:8];
         2'd2: b = rs2[23:16];
         2'd3: b = rs2[31:24];
         default: b = rs2[7:0];
      endcase
   end

   // One shared field inverter serves both AES directions: decryption undoes
   // the affine map first, encryption applies it after the inversion.
   assign aes_dec = (op == 3'd2) || (op == 3'd3);
   assign inv_in  = aes_dec ? ({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05)
                            : b;
   assign inv_out = gf_inv(inv_in);
   assign aes_x   = aes_dec ? inv_out
                            : (inv_out ^ {inv_out[6:0], inv_out[7]} ^ {inv_out[5:0], inv_out[7:6]}
                               ^ {inv_out[4:0], inv_out[7:5]} ^ {inv_out[3:0], inv_out[7:4]} ^ 8'h63);

   // MixColumns / InvMixColumns single-column coefficients, byte 0 first
   localparam logic [7:0] ENC_C [4] = '{8'h02, 8'h01, 8'h01, 8'h03};
   localparam logic [7:0] DEC_C [4] = '{8'h0E, 8'h09, 8'h0D, 8'h0B};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_mix
         assign mc_enc[8*gi +: 8] = gf_mul(aes_x, ENC_C[gi]);
         assign mc_dec[8*gi +: 8] = gf_mul(aes_x, DEC_C[gi]);
      end
   endgenerate

`ifdef ENC1S_SM4_EN
   localparam logic [7:0] SM4_S [256] = '{
      8'hD6,8'h90,8'hE9,8'hFE,8'hCC,8'hE1,8'h3D,8'hB7,8'h16,8'hB6,8'h14,8'hC2,8'h28,8'hFB,8'h2C,8'h05,
      8'h2B,8'h67,8'h9A,8'h76,8'h2A,8'hBE,8'h04,8'hC3,8'hAA,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
      8'h9C,8'h42,8'h50,8'hF4,8'h91,8'hEF,8'h98,8'h7A,8'h33,8'h54,8'h0B,8'h43,8'hED,8'hCF,8'hAC,8'h62,
      8'hE4,8'hB3,8'h1C,8'hA9,8'hC9,8'h08,8'hE8,8'h95,8'h80,8'hDF,8'h94,8'hFA,8'h75,8'h8F,8'h3F,8'hA6,
      8'h47,8'h07,8'hA7,8'hFC,8'hF3,8'h73,8'h17,8'hBA,8'h83,8'h59,8'h3C,8'h19,8'hE6,8'h85,8'h4F,8'hA8,
      8'h68,8'h6B,8'h81,8'hB2,8'h71,8'h64,8'hDA,8'h8B,8'hF8,8'hEB,8'h0F,8'h4B,8'h70,8'h56,8'h9D,8'h35,
      8'h1E,8'h24,8'h0E,8'h5E,8'h63,8'h58,8'hD1,8'hA2,8'h25,8'h22,8'h7C,8'h3B,8'h01,8'h21,8'h78,8'h87,
      8'hD4,8'h00,8'h46,8'h57,8'h9F,8'hD3,8'h27,8'h52,8'h4C,8'h36,8'h02,8'hE7,8'hA0,8'hC4,8'hC8,8'h9E,
      8'hEA,8'hBF,8'h8A,8'hD2,8'h40,8'hC7,8'h38,8'hB5,8'hA3,8'hF7,8'hF2,8'hCE,8'hF9,8'h61,8'h15,8'hA1,
      8'hE0,8'hAE,8'h5D,8'hA4,8'h9B,8'h34,8'h1A,8'h55,8'hAD,8'h93,8'h32,8'h30,8'hF5,8'h8C,8'hB1,8'hE3,
      8'h1D,8'hF6,8'hE2,8'h2E,8'h82,8'h66,8'hCA,8'h60,8'hC0,8'h29,8'h23,8'hAB,8'h0D,8'h53,8'h4E,8'h6F,
      8'hD5,8'hDB,8'h37,8'h45,8'hDE,8'hFD,8'h8E,8'h2F,8'h03,8'hFF,8'h6A,8'h72,8'h6D,8'h6C,8'h5B,8'h51,
      8'h8D,8'h1B,8'hAF,8'h92,8'hBB,8'hDD,8'hBC,8'h7F,8'h11,8'hD9,8'h5C,8'h41,8'h1F,8'h10,8'h5A,8'hD8,
      8'h0A,8'hC1,8'h31,8'h88,8'hA5,8'hCD,8'h7B,8'hBD,8'h2D,8'h74,8'hD0,8'h12,8'hB8,8'hE5,8'hB4,8'hB0,
      8'h89,8'h69,8'h97,8'h4A,8'h0C,8'h96,8'h77,8'h7E,8'h65,8'hB9,8'hF1,8'h09,8'hC5,8'h6E,8'hC6,8'h84,
      8'h18,8'hF0,8'h7D,8'hEC,8'h3A,8'hDC,8'h4D,8'h20,8'h79,8'hEE,8'h5F,8'h3E,8'hD7,8'hCB,8'h39,8'h48
   };

   logic [31:0] sm4_y;
   logic [31:0] sm4_enc;
   logic [31:0] sm4_key;

   assign sm4_y   = {24'h0, SM4_S[b]};
   // L  : y ^ rol2 ^ rol10 ^ rol18 ^ rol24      L' : y ^ rol13 ^ rol23
   assign sm4_enc = sm4_y ^ {sm4_y[29:0], sm4_y[31:30]} ^ {sm4_y[21:0], sm4_y[31:22]}
                          ^ {sm4_y[13:0], sm4_y[31:14]} ^ {sm4_y[7:0], sm4_y[31:8]};
   assign sm4_key = sm4_y ^ {sm4_y[18:0], sm4_y[31:19]} ^ {sm4_y[8:0], sm4_y[31:9]};
`endif

   always_comb begin
      w = 32'h0;
      case (op)
         3'd0: w = {24'h0, aes_x};
         3'd1: w = mc_enc;
         3'd2: w = {24'h0, aes_x};
         3'd3: w = mc_dec;
`ifdef ENC1S_SM4_EN
         3'd4: w = sm4_enc;
         3'd5: w = sm4_key;
`endif
         default: w = 32'h0;
      endcase
   end

   // Rotate the word back into the lane the source byte came from
   always_comb begin
      w_rot = w;
      case (sel)
         2'd0: w_rot = w;
         2'd1: w_rot = {w[23:0], w[31:24]};
         2'd2: w_rot = {w[15:0], w[31:16]};
         2'd3: w_rot = {w[7:0],  w[31:8]};
         default: w_rot = w;
      endcase
   end

   assign result_next = rs1 ^ w_rot;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_reg    <= 32'h0;
         valid_reg <= 1'b0;
      end else begin
         valid_reg <= valid_i;
         if (valid_i) rd_reg <= result_next;
      end
   end

   assign rd      = rd_reg;
   assign valid_o = valid_reg;

endmodule

// File: tb/tb_enc1s_unit.sv
// Testbench for enc1s_unit: directed vectors, reset/hold behaviour and a
// randomized sweep over every fn value against an independent model.
// Expected results are queued when an operation is issued and popped when
// the result is due.
`timescale 1ns/1ps

module tb_enc1s_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_i;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [4:0]  fn;
   logic        valid_o;
   logic [31:0] rd;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] exp_q [$];
   string       tag_q [$];
   logic [31:0] last_rd;

   logic [7:0] sbox  [256];
   logic [7:0] isbox [256];

   always #5 clk = ~clk;

   enc1s_unit dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (valid_i),
      .rs1     (rs1),
      .rs2     (rs2),
      .fn      (fn),
      .valid_o (valid_o),
      .rd      (rd)
   );

   // ---------------- reference model ----------------
   // carry-less product then reduction by 0x11B
   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (15'(a) << i);
      for (int i = 14; i >= 8; i--)
         if (p[i]) p = p ^ (15'h11B << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [31:0] m_rol(input logic [31:0] x, input int s);
      if (s == 0) return x;
      return (x << s) | (x >> (32 - s));
   endfunction

`ifdef ENC1S_SM4_EN
   function automatic logic [7:0] m_sm4(input logic [7:0] a);
      case (a)
         8'h00: return 8'hD6;
         8'h01: return 8'h90;
         8'h02: return 8'hE9;
         8'h10: return 8'h2B;
         default: return 8'h48;   // only 8'hFF is ever requested otherwise
      endcase
   endfunction
`endif

   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] s2,
                                         input logic [4:0] f);
      int         sh;
      logic [7:0] bb;
      logic [7:0] x;
      logic [31:0] w;
      sh = 8 * int'(f[1:0]);
      bb = 8'(s2 >> sh);
      w  = 32'h0;
      case (f[4:2])
         3'd0: w = {24'h0, sbox[bb]};
         3'd1: begin
            x = sbox[bb];
            w = {m_mul(x, 8'h03), x, x, m_mul(x, 8'h02)};
         end
         3'd2: w = {24'h0, isbox[bb]};
         3'd3: begin
            x = isbox[bb];
            w = {m_mul(x, 8'h0B), m_mul(x, 8'h0D), m_mul(x, 8'h09), m_mul(x, 8'h0E)};
         end
`ifdef ENC1S_SM4_EN
         3'd4: begin
            w = {24'h0, m_sm4(bb)};
            w = w ^ m_rol(w, 2) ^ m_rol(w, 10) ^ m_rol(w, 18) ^ m_rol(w, 24);
         end
         3'd5: begin
            w = {24'h0, m_sm4(bb)};
            w = w ^ m_rol(w, 13) ^ m_rol(w, 23);
         end
`endif
         default: w = 32'h0;
      endcase
      return a ^ m_rol(w, sh);
   endfunction

   // Build AES tables: brute-force inverse, bitwise affine map, then invert S.
   task automatic build_tables();
      logic [7:0] inv;
      logic [7:0] s;
      logic [7:0] c;
      c = 8'h63;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (m_mul(8'(a), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                   ^ inv[(i + 7) % 8] ^ c[i];
         sbox[a] = s;
      end
      for (int a = 0; a < 256; a++) isbox[sbox[a]] = 8'(a);
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, then check the outputs one unit after the edge.
   task automatic step(input logic v, input logic [31:0] a, input logic [31:0] s2,
                       input logic [4:0] f, input logic [31:0] exp, input string tag);
      logic [31:0] e;
      string       t;
      valid_i = v;
      rs1     = a;
      rs2     = s2;
      fn      = f;
      if (v && rst_n) begin
         exp_q.push_back(exp);
         tag_q.push_back(tag);
      end
      @(posedge clk);
      #1;
      if (!rst_n) last_rd = 32'h0;
      check({tag, "_valid"}, {31'h0, valid_o}, {31'h0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         last_rd = e;
         check(t, rd, e);
         $display("txn %s rs1=%08h rs2=%08h fn=%02h rd=%08h exp=%08h", t, a, s2, f, rd, e);
      end else begin
         check({tag, "_hold"}, rd, last_rd);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] s2;
      logic [31:0] sm4_exp;
      logic [7:0]  pick [5];
      pick = '{8'h00, 8'h01, 8'h02, 8'h10, 8'hFF};

      build_tables();
      last_rd = 32'h0;
      rst_n   = 1'b0;

      // reset with valid_i asserted: operation dropped, outputs cleared
      step(1'b1, 32'h1234_5678, 32'h0, 5'h00, 32'h0, "rst0");
      step(1'b1, 32'h1234_5678, 32'h0, 5'h04, 32'h0, "rst1");
      rst_n = 1'b1;

      // directed vectors
      step(1'b1, 32'h0000_0000, 32'h0000_0000, 5'h00, 32'h0000_0063, "aes_ef_0");
      step(1'b1, 32'h0000_0000, 32'h0000_0000, 5'h04, 32'hA563_63C6, "aes_em_0");
      step(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 5'h00, 32'hFFFF_FF9C, "aes_ef_x");
      step(1'b1, 32'h0000_0000, 32'h0000_5300, 5'h01, 32'h0000_ED00, "aes_ef_b1");
      step(1'b1, 32'h0000_0000, 32'h0000_0063, 5'h08, 32'h0000_0000, "aes_df_63");
`ifdef ENC1S_SM4_EN
      sm4_exp = 32'h9242_42D0;
`else
      sm4_exp = 32'h0000_0000;
`endif
      step(1'b1, 32'h0000_0000, 32'h0000_0001, 5'h10, sm4_exp, "sm4_e_01");
      step(1'b1, 32'hCAFE_F00D, 32'h0000_0000, 5'h18, 32'hCAFE_F00D, "resv6");

      // single pulse then idle: valid_o for one cycle, rd held
      step(1'b1, 32'h0000_0000, 32'h5300_0000, 5'h03, 32'hED00_0000, "pulse");
      step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h00, 32'h0, "idle0");
      step(1'b0, 32'h0000_0000, 32'h0000_0000, 5'h04, 32'h0, "idle1");

      // reset mid-run with valid_i asserted
      rst_n = 1'b0;
      step(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 5'h00, 32'h0, "rst_mid");
      rst_n = 1'b1;
      step(1'b0, 32'h0, 32'h0, 5'h00, 32'h0, "post_rst");

      // random sweep over every fn, with occasional idle cycles
      for (int f = 0; f < 32; f++) begin
         for (int k = 0; k < 3; k++) begin
            a  = $urandom;
            s2 = $urandom;
`ifdef ENC1S_SM4_EN
            if (f[4:2] == 3'd4 || f[4:2] == 3'd5)
               s2[8*f[1:0] +: 8] = pick[$urandom_range(0, 4)];
`else
            if (pick[0] != 8'h00) s2 = s2;
`endif
            step(1'b1, a, s2, 5'(f), model(a, s2, 5'(f)), $sformatf("rnd_fn%0d", f));
            if ($urandom_range(0, 3) == 0)
               step(1'b0, $urandom, $urandom, 5'($urandom), 32'h0, "gap");
         end
      end
      step(1'b0, 32'h0, 32'h0, 5'h00, 32'h0, "tail");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
